laser_brush_tracker: RTL and testbench
======================================

LASER_BRUSH_TRACKER -- requirements
Module: laser_brush_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent laser channels (1..4).
REQ-002 SHALL have parameter RADIUS_W, default 4: width of the per-channel brush radius.
REQ-003 SHALL have parameter ACQ_FRAMES, default 3: consecutive sampled frames needed to enter tracking.
REQ-004 SHALL have parameter TIMEOUT_FRAMES, default 8: consecutive missed frames before a channel is dropped.
REQ-005 SHALL have parameter SMOOTH_SHIFT, default 2: smoothing divisor exponent.
REQ-006 SHALL have port Clk, input, 1: system clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse marking a frame boundary.
REQ-009 SHALL have port sample_valid, input, 1: a laser sample is offered.
REQ-010 SHALL have port sample_ready, output, 1: the block accepts the offered sample this cycle.
REQ-011 SHALL have port sample_ch, input, clog2(NUM_CH) (min 1): the channel the sample belongs to.
REQ-012 SHALL have ports sample_x and sample_y, input, 11 each: camera coordinates at 2x VGA resolution.
REQ-013 SHALL have port radius, input, NUM_CH*RADIUS_W: packed per-channel brush radius in pixels; channel 0 in the LSBs.
REQ-014 SHALL have ports VGA_X and VGA_Y, input, 10 each: the current pixel being drawn.
REQ-015 SHALL have port hit, output, 1: the registered pixel lies inside an active brush.
REQ-016 SHALL have port hit_ch, output, clog2(NUM_CH): the index of the hitting channel.
REQ-017 SHALL have port tracking, output, NUM_CH: channel state is TRACK or COAST.

Function
REQ-018 A sample SHALL be accepted when sample_valid and sample_ready are both high; sample_ready SHALL be low for exactly the cycle after an acceptance and high otherwise.
REQ-019 The accepted coordinate SHALL be halved by dropping bit 0, then clamped to x 0..639 and y 0..479.
REQ-020 Each channel SHALL run the FSM IDLE -> ACQUIRE -> TRACK <-> COAST -> IDLE.
REQ-021 In IDLE, an accepted sample SHALL load the position directly, set acq_cnt=1 and go to ACQUIRE.
REQ-022 At frame_tick in ACQUIRE: with no sample since the last tick, the channel SHALL go to IDLE; otherwise acq_cnt SHALL increment, and when it reaches ACQ_FRAMES the channel SHALL go to TRACK.
REQ-023 At frame_tick in TRACK with no sample this frame, the channel SHALL go to COAST with miss_cnt=1.
REQ-024 In COAST, an accepted sample SHALL return the channel to TRACK and clear miss_cnt; otherwise each frame_tick SHALL increment miss_cnt, and at TIMEOUT_FRAMES the channel SHALL go to IDLE.
REQ-025 When frame_tick coincides with an acceptance for the same channel, the sample SHALL count toward the frame that is ending.
REQ-026 Outside IDLE, position SHALL update as pos + ((new - pos) >>> SMOOTH_SHIFT), using 12-bit signed arithmetic, with the result clamped to the screen range.
REQ-027 A channel SHALL hit when its state is TRACK or COAST and dx*dx + dy*dy <= r*r, evaluated with at least 22-bit unsigned products; r=0 SHALL hit the single centre pixel.
REQ-028 When several channels hit the same pixel, the lowest channel index SHALL win hit_ch.
REQ-029 hit and hit_ch SHALL be registered with exactly one cycle of latency from VGA_X/VGA_Y; hit_ch SHALL be 0 whenever hit is 0.

Reset
REQ-030 Reset SHALL set all channels to IDLE, set positions to (320,240) and clear acq_cnt, miss_cnt and the per-frame seen flags.
REQ-031 Reset SHALL drive hit=0, hit_ch=0 and tracking=0 on the next cycle, and sample_ready=1.
REQ-032 Reset during an accepted sample SHALL discard that sample.

Configuration
REQ-033 With LASER_BRUSH_SMOOTH_EN defined, the block SHALL apply REQ-026 smoothing.
REQ-034 Without LASER_BRUSH_SMOOTH_EN, every accepted sample SHALL load the position directly, and SMOOTH_SHIFT SHALL be ignored.

Structure
REQ-035 Package laser_pkg SHALL hold the channel state enum, the screen limit constants (639, 479, 320, 240) and the coordinate typedefs.
REQ-036 The per-channel FSM, counters and position register SHALL be a sub-module laser_channel, instantiated NUM_CH times; hit arbitration and the output register stay in the top level.

Verification
REQ-037 A bench SHALL cover: ch0 samples (640,480) in 3 consecutive frames -> tracking[0]=1 after the 3rd frame_tick; pixel (320,240) with radius 2 -> hit=1 one cycle later; pixel (323,240) -> hit=0.
REQ-038 A bench SHALL cover: ch0 in TRACK with no samples for 8 frames -> tracking[0]=1 through the 7th tick and 0 after the 8th; a sample at the 4th missed frame returns the channel to TRACK.
REQ-039 A bench SHALL cover: smoothing on with pos=100 and a sample at x=2*200 -> pos=125; smoothing off -> pos=200.
REQ-040 A bench SHALL cover: ch0 and ch1 both tracking at (50,50) with radius 3 -> pixel (50,50) gives hit=1 and hit_ch=0.
REQ-041 A bench SHALL cover: back-to-back sample_valid -> acceptance in alternate cycles only; sample x=2000 -> clamped to 639.
REQ-042 A bench SHALL cover: Reset asserted in ACQUIRE while a sample is accepted -> all IDLE, hit=0, and that sample is discarded.

Source files
------------

// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// laser_pkg : channel state, coordinate types and screen limits shared by the
//             laser brush tracker.  Rev 1.0
// ============================================================================
package laser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2,
      ST_COAST   = 2'd3
   } ch_state_t;

   typedef logic [9:0]         coord_t;
   typedef logic signed [11:0] scoord_t;

   localparam coord_t X_MAX    = 10'd639;
   localparam coord_t Y_MAX    = 10'd479;
   localparam coord_t X_CENTER = 10'd320;
   localparam coord_t Y_CENTER = 10'd240;

   function automatic coord_t clamp_coord(input scoord_t v, input coord_t lim);
      if (v < 0)
         return '0;
      else if (v > $signed({2'b00, lim}))
         return lim;
      else
         return v[9:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/laser_channel.sv
`default_nettype none
// ============================================================================
// laser_channel : per-channel acquire/track/coast FSM and brush position.
//                 Smoothing enabled by defining LASER_BRUSH_SMOOTH_EN.  Rev 1.0
// ============================================================================
module laser_channel
   import laser_pkg::*;
#(
   parameter int ACQ_FRAMES     = 3,
   parameter int TIMEOUT_FRAMES = 8,
   parameter int SMOOTH_SHIFT   = 2
) (
   input  logic   Clk,
   input  logic   Reset,
   input  logic   frame_tick,
   input  logic   accept,
   input  coord_t new_x,
   input  coord_t new_y,
   output logic   tracking,
   output coord_t pos_x,
   output coord_t pos_y
);

   localparam int ACQ_W  = $clog2(ACQ_FRAMES + 1);
   localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);

   ch_state_t         state, state_nxt;
   logic [ACQ_W-1:0]  acq_cnt, acq_nxt;
   logic [MISS_W-1:0] miss_cnt, miss_nxt;
   logic              seen, seen_nxt;
   coord_t            px_nxt, py_nxt;
   coord_t            upd_x, upd_y;

   function automatic coord_t smooth(input coord_t pos, input coord_t tgt, input coord_t lim);
      scoord_t diff;
      scoord_t step;
      diff = scoord_t'({2'b00, tgt}) - scoord_t'({2'b00, pos});
      step = diff >>> SMOOTH_SHIFT;
      return clamp_coord(scoord_t'({2'b00, pos}) + step, lim);
   endfunction

`ifdef LASER_BRUSH_SMOOTH_EN
   assign upd_x = smooth(pos_x, new_x, X_MAX);
   assign upd_y = smooth(pos_y, new_y, Y_MAX);
`else
   assign upd_x = new_x;
   assign upd_y = new_y;
`endif

   // A sample coinciding with frame_tick belongs to the frame that is ending.
   always_comb begin
      state_nxt = state;
      acq_nxt   = acq_cnt;
      miss_nxt  = miss_cnt;
      seen_nxt  = seen;
      px_nxt    = pos_x;
      py_nxt    = pos_y;
      if (accept && state != ST_IDLE) begin
         px_nxt = upd_x;
         py_nxt = upd_y;
      end
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               px_nxt    = new_x;
               py_nxt    = new_y;
               acq_nxt   = ACQ_W'(1);
               seen_nxt  = !frame_tick;
               state_nxt = ST_ACQUIRE;
            end
         end
         ST_ACQUIRE: begin
            if (frame_tick) begin
               seen_nxt = 1'b0;
               if (!(seen || accept)) begin
                  acq_nxt   = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  acq_nxt = acq_cnt + ACQ_W'(1);
                  if (acq_cnt + ACQ_W'(1) >= ACQ_W'(ACQ_FRAMES))
                     state_nxt = ST_TRACK;
               end
            end else if (accept) begin
               seen_nxt = 1'b1;
            end
         end
         ST_TRACK: begin
            if (frame_tick) begin
               seen_nxt = 1'b0;
               if (!(seen || accept)) begin
                  miss_nxt  = MISS_W'(1);
                  state_nxt = ST_COAST;
               end
            end else if (accept) begin
               seen_nxt = 1'b1;
            end
         end
         ST_COAST: begin
            if (accept) begin
               miss_nxt  = '0;
               seen_nxt  = !frame_tick;
               state_nxt = ST_TRACK;
            end else if (frame_tick) begin
               if (miss_cnt + MISS_W'(1) >= MISS_W'(TIMEOUT_FRAMES)) begin
                  miss_nxt  = '0;
                  acq_nxt   = '0;
                  seen_nxt  = 1'b0;
                  state_nxt = ST_IDLE;
               end else begin
                  miss_nxt = miss_cnt + MISS_W'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= ST_IDLE;
         acq_cnt  <= '0;
         miss_cnt <= '0;
         seen     <= 1'b0;
         pos_x    <= X_CENTER;
         pos_y    <= Y_CENTER;
      end else begin
         state    <= state_nxt;
         acq_cnt  <= acq_nxt;
         miss_cnt <= miss_nxt;
         seen     <= seen_nxt;
         pos_x    <= px_nxt;
         pos_y    <= py_nxt;
      end
   end

   assign tracking = (state == ST_TRACK) || (state == ST_COAST);

endmodule
`default_nettype wire

// File: rtl/laser_brush_tracker.sv
`default_nettype none
// ============================================================================
// laser_brush_tracker : multi-channel laser spot tracker with brush hit test.
//                       Smoothing enabled by defining LASER_BRUSH_SMOOTH_EN.  Rev 1.0
// ============================================================================
module laser_brush_tracker
   import laser_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int RADIUS_W       = 4,
   parameter int ACQ_FRAMES     = 3,
   parameter int TIMEOUT_FRAMES = 8,
   parameter int SMOOTH_SHIFT   = 2,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       frame_tick,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   input  logic [CH_W-1:0]            sample_ch,
   input  logic [10:0]                sample_x,
   input  logic [10:0]                sample_y,
   input  logic [NUM_CH*RADIUS_W-1:0] radius,
   input  logic [9:0]                 VGA_X,
   input  logic [9:0]                 VGA_Y,
   output logic                       hit,
   output logic [CH_W-1:0]            hit_ch,
   output logic [NUM_CH-1:0]          tracking
);

   logic        accept;
   logic [10:0] half_x, half_y;
   coord_t      cx, cy;
   logic [NUM_CH-1:0] in_brush;
   logic              hit_any;
   logic [CH_W-1:0]   win_ch;

   assign accept = sample_valid && sample_ready;

   always_ff @(posedge Clk) begin
      if (Reset)
         sample_ready <= 1'b1;
      else
         sample_ready <= !accept;
   end

   assign half_x = sample_x >> 1;
   assign half_y = sample_y >> 1;
   assign cx     = clamp_coord(scoord_t'({1'b0, half_x}), X_MAX);
   assign cy     = clamp_coord(scoord_t'({1'b0, half_y}), Y_MAX);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      coord_t      px, py;
      logic [11:0] dx, dy, ndx, ndy;
      logic [21:0] adx, ady, rr;

      laser_channel #(
         .ACQ_FRAMES     (ACQ_FRAMES),
         .TIMEOUT_FRAMES (TIMEOUT_FRAMES),
         .SMOOTH_SHIFT   (SMOOTH_SHIFT)
      ) u_channel (
         .Clk        (Clk),
         .Reset      (Reset),
         .frame_tick (frame_tick),
         .accept     (accept && (sample_ch == CH_W'(i))),
         .new_x      (cx),
         .new_y      (cy),
         .tracking   (tracking[i]),
         .pos_x      (px),
         .pos_y      (py)
      );

      // Absolute distances widened to 22 bits so squares cannot overflow.
      assign dx  = {2'b00, VGA_X} - {2'b00, px};
      assign dy  = {2'b00, VGA_Y} - {2'b00, py};
      assign ndx = -dx;
      assign ndy = -dy;
      assign adx = {11'd0, (dx[11] ? ndx[10:0] : dx[10:0])};
      assign ady = {11'd0, (dy[11] ? ndy[10:0] : dy[10:0])};
      assign rr  = 22'(radius[i*RADIUS_W +: RADIUS_W]) * 22'(radius[i*RADIUS_W +: RADIUS_W]);
      assign in_brush[i] = tracking[i] && ((adx * adx + ady * ady) <= rr);
   end

   // Scan downward so the lowest hitting index is the last one written.
   always_comb begin
      hit_any = 1'b0;
      win_ch  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (in_brush[i]) begin
            hit_any = 1'b1;
            win_ch  = CH_W'(i);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hit    <= 1'b0;
         hit_ch <= '0;
      end else begin
         hit    <= hit_any;
         hit_ch <= win_ch;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_laser_brush_tracker.sv
`default_nettype none
// ============================================================================
// tb_laser_brush_tracker : scoreboard bench for laser_brush_tracker (2 channels).
//                          Rev 1.0
// ============================================================================
module tb_laser_brush_tracker;

`ifdef LASER_BRUSH_SMOOTH_EN
   localparam int SMOOTH_X = 125;
`else
   localparam int SMOOTH_X = 200;
`endif

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       sample_valid = 1'b0;
   logic       sample_ready;
   logic [0:0] sample_ch = '0;
   logic [10:0] sample_x = '0;
   logic [10:0] sample_y = '0;
   logic [7:0] radius = '0;
   logic [9:0] VGA_X = '0;
   logic [9:0] VGA_Y = '0;
   logic       hit;
   logic [0:0] hit_ch;
   logic [1:0] tracking;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic  h;
      logic  ch;
      string nm;
   } exp_t;
   exp_t exp_q[$];

   laser_brush_tracker dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .frame_tick   (frame_tick),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_ch    (sample_ch),
      .sample_x     (sample_x),
      .sample_y     (sample_y),
      .radius       (radius),
      .VGA_X        (VGA_X),
      .VGA_Y        (VGA_Y),
      .hit          (hit),
      .hit_ch       (hit_ch),
      .tracking     (tracking)
   );

   always #5 Clk = ~Clk;

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      sample_valid = 1'b0;
      frame_tick = 1'b0;
      cyc();
      Reset = 1'b0;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic send(input int ch, input int x, input int y);
      int guard = 0;
      while (!sample_ready && guard < 20) begin
         cyc();
         guard++;
      end
      checks++;
      if (sample_ready !== 1'b1)
         $display("FAIL send_ready_timeout ready=%b required=1", sample_ready);
      else
         passes++;
      sample_valid = 1'b1;
      sample_ch = ch[0:0];
      sample_x = x[10:0];
      sample_y = y[10:0];
      cyc();
      sample_valid = 1'b0;
      cyc();
   endtask

   // Drives one pixel and records what the registered output must show after the edge.
   task automatic probe(input int x, input int y, input logic eh, input logic ech, input string nm);
      VGA_X = x[9:0];
      VGA_Y = y[9:0];
      exp_q.push_back('{eh, ech, nm});
      cyc();
   endtask

   task automatic test_reset();
      exp_t e;
      VGA_X = 10'd320;
      VGA_Y = 10'd240;
      radius = 8'hFF;
      exp_q.push_back('{1'b0, 1'b0, "reset_hit"});
      do_reset();
      e = exp_q.pop_front();
      checks++;
      if (hit !== e.h) $display("FAIL %s got=%b want=%b", e.nm, hit, e.h); else passes++;
      checks++;
      if (hit_ch !== 1'b0) $display("FAIL reset_hit_ch got=%b want=0", hit_ch); else passes++;
      checks++;
      if (tracking !== 2'b00) $display("FAIL reset_tracking got=%b want=00", tracking); else passes++;
      checks++;
      if (sample_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", sample_ready); else passes++;
   endtask

   task automatic test_acquire();
      int px[5] = '{320, 323, 322, 320, 321};
      int py[5] = '{240, 240, 240, 243, 241};
      bit eh[5] = '{1, 0, 1, 0, 1};
      exp_t e;
      do_reset();
      radius = {4'd0, 4'd2};
      send(0, 640, 480);
      frame();
      checks++;
      if (tracking !== 2'b00) $display("FAIL acq_after_tick1 got=%b want=00", tracking); else passes++;
      send(0, 640, 480);
      frame();
      send(0, 640, 480);
      frame();
      checks++;
      if (tracking[0] !== 1'b1) $display("FAIL acq_after_tick3 got=%b want=1", tracking[0]); else passes++;
      for (int i = 0; i < 5; i++) begin
         probe(px[i], py[i], eh[i], 1'b0, $sformatf("acq_pix%0d", i));
         e = exp_q.pop_front();
         checks++;
         if (hit !== e.h || hit_ch !== e.ch)
            $display("FAIL %s hit/ch got=%b/%b want=%b/%b", e.nm, hit, hit_ch, e.h, e.ch);
         else
            passes++;
      end
   endtask

   task automatic test_coast();
      for (int k = 1; k <= 3; k++) begin
         frame();
         checks++;
         if (tracking[0] !== 1'b1) $display("FAIL coast_miss%0d got=%b want=1", k, tracking[0]); else passes++;
      end
      send(0, 640, 480);
      frame();
      for (int k = 1; k <= 8; k++) begin
         frame();
         checks++;
         if (tracking[0] !== (k < 8))
            $display("FAIL timeout_tick%0d got=%b want=%b", k, tracking[0], (k < 8));
         else
            passes++;
      end
   endtask

   task automatic test_smooth();
      int px[4];
      bit eh[4] = '{1, 0, 0, 0};
      exp_t e;
      px = '{SMOOTH_X, SMOOTH_X + 1, SMOOTH_X - 1, (SMOOTH_X == 125) ? 200 : 125};
      do_reset();
      radius = {4'd0, 4'd0};
      send(0, 200, 200);
      frame();
      send(0, 200, 200);
      frame();
      checks++;
      if (tracking[0] !== 1'b1) $display("FAIL smooth_track got=%b want=1", tracking[0]); else passes++;
      send(0, 400, 200);
      for (int i = 0; i < 4; i++) begin
         probe(px[i], 100, eh[i], 1'b0, $sformatf("smooth_x%0d", px[i]));
         e = exp_q.pop_front();
         checks++;
         if (hit !== e.h || hit_ch !== e.ch)
            $display("FAIL %s hit/ch got=%b/%b want=%b/%b", e.nm, hit, hit_ch, e.h, e.ch);
         else
            passes++;
      end
   endtask

   task automatic test_priority();
      int px[6] = '{50, 53, 54, 50, 51, 50};
      int py[6] = '{50, 50, 50, 47, 50, 50};
      bit eh[6] = '{1, 1, 0, 1, 1, 1};
      bit ec[6] = '{0, 0, 0, 0, 1, 0};
      exp_t e;
      do_reset();
      radius = {4'd3, 4'd3};
      for (int f = 0; f < 2; f++) begin
         send(0, 100, 100);
         send(1, 100, 100);
         frame();
      end
      checks++;
      if (tracking !== 2'b11) $display("FAIL prio_tracking got=%b want=11", tracking); else passes++;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) radius = {4'd3, 4'd0};
         probe(px[i], py[i], eh[i], ec[i], $sformatf("prio_pix%0d", i));
         e = exp_q.pop_front();
         checks++;
         if (hit !== e.h || hit_ch !== e.ch)
            $display("FAIL %s hit/ch got=%b/%b want=%b/%b", e.nm, hit, hit_ch, e.h, e.ch);
         else
            passes++;
      end
   endtask

   task automatic test_back_to_back();
      bit rdy_q[$];
      bit r;
      int px[3] = '{639, 638, 639};
      int py[3] = '{50, 50, 51};
      bit eh[3] = '{1, 0, 0};
      bit ec[3] = '{1, 0, 0};
      exp_t e;
      do_reset();
      radius = {4'd0, 4'd0};
      sample_valid = 1'b1;
      sample_ch = 1'b1;
      sample_x = 11'd2000;
      sample_y = 11'd100;
      for (int i = 0; i < 6; i++) begin
         rdy_q.push_back(i % 2 == 0);
         r = rdy_q.pop_front();
         checks++;
         if (sample_ready !== r)
            $display("FAIL b2b_ready%0d got=%b want=%b", i, sample_ready, r);
         else
            passes++;
         cyc();
      end
      sample_valid = 1'b0;
      cyc();
      frame();
      send(1, 2000, 100);
      frame();
      checks++;
      if (tracking !== 2'b10) $display("FAIL b2b_tracking got=%b want=10", tracking); else passes++;
      for (int i = 0; i < 3; i++) begin
         probe(px[i], py[i], eh[i], ec[i], $sformatf("clamp_pix%0d", i));
         e = exp_q.pop_front();
         checks++;
         if (hit !== e.h || hit_ch !== e.ch)
            $display("FAIL %s hit/ch got=%b/%b want=%b/%b", e.nm, hit, hit_ch, e.h, e.ch);
         else
            passes++;
      end
   endtask

   task automatic test_reset_discard();
      do_reset();
      radius = {4'd0, 4'd5};
      VGA_X = 10'd100;
      VGA_Y = 10'd100;
      send(0, 200, 200);
      frame();
      sample_valid = 1'b1;
      sample_ch = 1'b0;
      sample_x = 11'd600;
      sample_y = 11'd600;
      Reset = 1'b1;
      checks++;
      if (sample_ready !== 1'b1) $display("FAIL discard_pre_ready got=%b want=1", sample_ready); else passes++;
      cyc();
      Reset = 1'b0;
      sample_valid = 1'b0;
      checks++;
      if (tracking !== 2'b00) $display("FAIL discard_tracking got=%b want=00", tracking); else passes++;
      checks++;
      if (hit !== 1'b0) $display("FAIL discard_hit got=%b want=0", hit); else passes++;
      checks++;
      if (sample_ready !== 1'b1) $display("FAIL discard_ready got=%b want=1", sample_ready); else passes++;
      frame();
      send(0, 200, 200);
      frame();
      checks++;
      if (tracking[0] !== 1'b0) $display("FAIL discard_not_counted got=%b want=0", tracking[0]); else passes++;
   endtask

   initial begin
      test_reset();
      test_acquire();
      test_coast();
      test_smooth();
      test_priority();
      test_back_to_back();
      test_reset_discard();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired passed=%0d total=%0d", passes, checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
